// File: rtl/cpu_dmem_responder.sv
// cpu_dmem_responder -- responder side of the CPU data-memory port.
//
// Decodes a word-addressed data RAM at the bottom of the address space and a
// 4 KiB MMIO page at MMIO_BASE. The MMIO page holds a free-running 64-bit
// cycle counter and a byte-wide console TX FIFO drained over tx_valid/tx_ready.
// Reads are combinational (the single-cycle core uses them in the same cycle);
// writes commit on the rising clock edge.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   MemWriteEnable  per-byte write lanes (0 = read/idle)
//   Addr_in         byte address, bits [1:0] ignored
//   Data_in         write data
//   Data_out        combinational read data
//   tx_data/tx_valid/tx_ready  TX FIFO drain port
//   bus_err         (only with DMEM_BOUNDS_ERR_EN) unmapped/undefined access
//
// Optional feature macro: DMEM_BOUNDS_ERR_EN adds the bus_err output and the
// sticky STATUS bit5 access-error flag.
//
// MMIO map (word offsets): 0x00 CNT_LO, 0x04 CNT_HI, 0x08 TX_DATA (WO),
// 0x0C STATUS {count[15:8], berr[5], ovf[4], empty[1], full[0]}, 0x10 CTRL.
module cpu_dmem_responder #(
    parameter int          RAM_AW    = 10,
    parameter int          FIFO_AW   = 3,
    parameter logic [31:0] MMIO_BASE = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  MemWriteEnable,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    output logic [31:0] Data_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
`ifdef DMEM_BOUNDS_ERR_EN
    ,
    output logic        bus_err
`endif
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [9:0] OFF_CNT_LO = 10'd0;
    localparam logic [9:0] OFF_CNT_HI = 10'd1;
    localparam logic [9:0] OFF_TX     = 10'd2;
    localparam logic [9:0] OFF_STATUS = 10'd3;
    localparam logic [9:0] OFF_CTRL   = 10'd4;

    // ---------------- decode ----------------
    logic              mmio_hit, ram_hit, reg_def, access_err;
    logic [9:0]        reg_idx;
    logic [RAM_AW-1:0] ram_idx;

    // MMIO takes priority so a low MMIO_BASE can never alias into RAM writes.
    assign mmio_hit   = (Addr_in[31:12] == MMIO_BASE[31:12]);
    assign ram_hit    = !mmio_hit && (Addr_in[31:RAM_AW+2] == '0);
    assign reg_idx    = Addr_in[11:2];
    assign ram_idx    = Addr_in[RAM_AW+1:2];
    assign reg_def    = (reg_idx <= OFF_CTRL);
    assign access_err = mmio_hit ? !reg_def : !ram_hit;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^Addr_in[1:0];

    logic ctrl_wr, tx_wr, status_wr;
    assign ctrl_wr   = mmio_hit && (reg_idx == OFF_CTRL)   && MemWriteEnable[0];
    assign tx_wr     = mmio_hit && (reg_idx == OFF_TX)     && MemWriteEnable[0];
    assign status_wr = mmio_hit && (reg_idx == OFF_STATUS) && MemWriteEnable[0];

    // ---------------- data RAM (not reset) ----------------
    logic [3:0][7:0] ram [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (!rst && ram_hit) begin
            for (int i = 0; i < 4; i++)
                if (MemWriteEnable[i]) ram[ram_idx][i] <= Data_in[8*i +: 8];
        end
    end

    // ---------------- cycle counter ----------------
    logic [63:0] cnt, cnt_nxt;
    logic        cnt_en;

    // Clear beats increment; the enable used here is the pre-write value.
    always_comb begin
        cnt_nxt = cnt;
        if (ctrl_wr && Data_in[1]) cnt_nxt = '0;
        else if (cnt_en)           cnt_nxt = cnt + 64'd1;
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, empty, enq, deq, ovf, berr;

    assign full     = (count == (FIFO_AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign tx_data  = fifo_mem[rd_ptr];
    assign deq      = tx_valid && tx_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign enq      = tx_wr && (!full || deq);

    always_ff @(posedge clk) begin
        if (!rst && enq) fifo_mem[wr_ptr] <= Data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            cnt_en <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (ctrl_wr) cnt_en <= Data_in[0];
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (tx_wr && full && !deq)         ovf <= 1'b1;
            else if (status_wr && Data_in[4])  ovf <= 1'b0;
        end
    end

`ifdef DMEM_BOUNDS_ERR_EN
    logic berr_q;
    assign bus_err = access_err;
    assign berr    = berr_q;

    // Set wins over clear: the STATUS write itself is a mapped access.
    always_ff @(posedge clk) begin
        if (rst)                            berr_q <= 1'b0;
        else if (access_err)                berr_q <= 1'b1;
        else if (status_wr && Data_in[5])   berr_q <= 1'b0;
    end
`else
    logic unused_err;
    assign unused_err = access_err;
    assign berr       = 1'b0;
`endif

    // ---------------- read mux ----------------
    logic [31:0] status;
    assign status = {16'h0, 8'(count), 2'b00, berr, ovf, 2'b00, empty, full};

    always_comb begin
        Data_out = '0;
        if (mmio_hit) begin
            case (reg_idx)
                OFF_CNT_LO: Data_out = cnt[31:0];
                OFF_CNT_HI: Data_out = cnt[63:32];
                OFF_STATUS: Data_out = status;
                OFF_CTRL:   Data_out = {31'b0, cnt_en};
                default:    Data_out = '0;
            endcase
        end else if (ram_hit) begin
            Data_out = ram[ram_idx];
        end
    end
endmodule

// File: tb/tb_cpu_dmem_responder.sv
module tb_cpu_dmem_responder;
    localparam logic [31:0] CNT_LO = 32'hF000_0000;
    localparam logic [31:0] CNT_HI = 32'hF000_0004;
    localparam logic [31:0] TXD    = 32'hF000_0008;
    localparam logic [31:0] STAT   = 32'hF000_000C;
    localparam logic [31:0] CTRL   = 32'hF000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  MemWriteEnable = 4'h0;
    logic [31:0] Addr_in = 32'h0;
    logic [31:0] Data_in = 32'h0;
    logic [31:0] Data_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
`ifdef DMEM_BOUNDS_ERR_EN
    logic        bus_err;
`endif

    int checks = 0;
    int errors = 0;

    cpu_dmem_responder dut (
        .clk(clk), .rst(rst), .MemWriteEnable(MemWriteEnable), .Addr_in(Addr_in),
        .Data_in(Data_in), .Data_out(Data_out), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef DMEM_BOUNDS_ERR_EN
        , .bus_err(bus_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        Addr_in = a; Data_in = d; MemWriteEnable = be;
        @(posedge clk); #1;
        MemWriteEnable = 4'h0; Addr_in = 32'h0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Addr_in = a;
        #1;
        check(tag, Data_out, exp);
        Addr_in = 32'h0;
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, {31'b0, tx_valid}, 32'd1);
        check({tag, "_data"}, {24'b0, tx_data}, {24'b0, exp});
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    initial begin
        // ---- reset ----
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        rd("rst_status", STAT, 32'h0000_0002);
        rd("rst_cnt_lo", CNT_LO, 32'h0);
        rd("rst_ctrl", CTRL, 32'h0);

        // ---- RAM byte lanes and decode ----
        wr(32'h40, 32'h1122_3344, 4'b1111);
        wr(32'h40, 32'hAABB_CCDD, 4'b0101);
        rd("ram_lanes", 32'h40, 32'h11BB_33DD);
        wr(32'h0, 32'h0102_0304, 4'b1111);
        wr(32'h0001_0000, 32'hDEAD_BEEF, 4'b1111);
        rd("ram_no_alias", 32'h0, 32'h0102_0304);
        rd("unmapped_rd", 32'h0001_0000, 32'h0);
        rd("mmio_undef", 32'hF000_0020, 32'h0);
        rd("tx_data_rd", TXD, 32'h0);

        // ---- counter ----
        wr(CTRL, 32'h1, 4'h1);
        repeat (10) @(posedge clk);
        #1;
        rd("cnt_10", CNT_LO, 32'd10);
        rd("ctrl_en", CTRL, 32'h1);
        wr(CTRL, 32'h0, 4'h1);
        @(negedge clk);
        force dut.cnt = 64'h0000_0000_FFFF_FFFE;
        @(negedge clk);
        release dut.cnt;
        rd("cnt_preset", CNT_LO, 32'hFFFF_FFFE);
        wr(CTRL, 32'h1, 4'h1);
        repeat (2) @(posedge clk);
        #1;
        rd("cnt_wrap_hi", CNT_HI, 32'h1);
        rd("cnt_wrap_lo", CNT_LO, 32'h0);
        wr(CTRL, 32'h2, 4'h1);
        rd("cnt_clr_lo", CNT_LO, 32'h0);
        rd("cnt_clr_hi", CNT_HI, 32'h0);
        rd("ctrl_clr_rd", CTRL, 32'h0);

        // ---- FIFO fill, overflow, drain ----
        for (int i = 0; i < 8; i++) wr(TXD, 32'h41 + i, 4'h1);
        rd("fifo_full", STAT, 32'h0000_0801);
        wr(TXD, 32'h49, 4'h1);
        rd("fifo_ovf", STAT, 32'h0000_0811);
        wr(STAT, 32'h10, 4'h1);
        rd("ovf_clr", STAT, 32'h0000_0801);
        for (int i = 0; i < 8; i++) pop("drain", 8'(8'h41 + i));
        check("drained_valid", {31'b0, tx_valid}, 32'd0);
        rd("drained_status", STAT, 32'h0000_0002);

        // ---- full with simultaneous enqueue + dequeue ----
        for (int i = 0; i < 8; i++) wr(TXD, 32'h41 + i, 4'h1);
        @(negedge clk);
        Addr_in = TXD; Data_in = 32'h50; MemWriteEnable = 4'h1; tx_ready = 1'b1;
        @(posedge clk); #1;
        MemWriteEnable = 4'h0; Addr_in = 32'h0; tx_ready = 1'b0;
        rd("full_enq_deq", STAT, 32'h0000_0801);
        for (int i = 0; i < 7; i++) pop("rest", 8'(8'h42 + i));
        pop("last50", 8'h50);
        check("empty_again", {31'b0, tx_valid}, 32'd0);

        // ---- empty FIFO, no bypass ----
        @(negedge clk);
        Addr_in = TXD; Data_in = 32'h5A; MemWriteEnable = 4'h1;
        #1 check("no_bypass", {31'b0, tx_valid}, 32'd0);
        @(posedge clk); #1;
        MemWriteEnable = 4'h0; Addr_in = 32'h0;
        pop("first5a", 8'h5A);
        check("valid_falls", {31'b0, tx_valid}, 32'd0);

        // ---- reset mid-stream ----
        wr(TXD, 32'h01, 4'h1);
        wr(TXD, 32'h02, 4'h1);
        wr(TXD, 32'h03, 4'h1);
        wr(CTRL, 32'h1, 4'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; Addr_in = TXD; Data_in = 32'h77; MemWriteEnable = 4'h1;
        @(posedge clk); #1;
        rst = 1'b0; MemWriteEnable = 4'h0; Addr_in = 32'h0;
        check("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
        rd("mid_rst_cnt", CNT_LO, 32'h0);
        rd("mid_rst_ctrl", CTRL, 32'h0);
        rd("mid_rst_status", STAT, 32'h0000_0002);
        rd("mid_rst_ram", 32'h40, 32'h11BB_33DD);
        @(posedge clk); #1;
        rd("cnt_stays_0", CNT_LO, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
